// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS execute unit.
// Main-control ALU ops, R-type function codes and ALU control codes.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        CTL_AND = 3'b000,
        CTL_OR  = 3'b001,
        CTL_ADD = 3'b010,
        CTL_INV = 3'b011,
        CTL_SUB = 3'b110,
        CTL_SLT = 3'b111
    } alu_ctl_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder.
// Maps main-control op and R-type function field to a 3-bit ALU control code.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] func,
    output logic [2:0] aluctrl
);

    alu_ctl_e ctl;

    // Fixed ops for memory/branch; R-type decoded from the function field
    always_comb begin
        ctl = CTL_INV;
        unique case (aluop)
            ALUOP_ADD: ctl = CTL_ADD;
            ALUOP_SUB: ctl = CTL_SUB;
            ALUOP_RTYPE: begin
                unique case (func)
                    F_ADD:   ctl = CTL_ADD;
                    F_SUB:   ctl = CTL_SUB;
                    F_AND:   ctl = CTL_AND;
                    F_OR:    ctl = CTL_OR;
                    F_SLT:   ctl = CTL_SLT;
                    default: ctl = CTL_INV;
                endcase
            end
            default: ctl = CTL_INV;
        endcase
    end

    assign aluctrl = ctl;

endmodule

// File: rtl/alu_unit.sv
// Registered 32-bit integer execute unit.
// Decodes the ALU control, computes the result and registers result/zero/valid.
module alu_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  func,
    input  logic [1:0]  aluop,
    output logic [2:0]  aluctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        out_valid
);

    logic [2:0]  ctl;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        zero_d;
    logic        zero_q;
    logic        valid_q;

    alu_ctrl_dec u_dec (
        .aluop   (aluop),
        .func    (func),
        .aluctrl (ctl)
    );

    // Datapath: unused codes (011/100/101) yield zero
    always_comb begin
        result_d = 32'd0;
        unique case (ctl)
            CTL_AND: result_d = a & b;
            CTL_OR:  result_d = a | b;
            CTL_ADD: result_d = a + b;
            CTL_SUB: result_d = a - b;
            CTL_SLT: result_d = {31'd0, $signed(a) < $signed(b)};
            default: result_d = 32'd0;
        endcase
        zero_d = (result_d == 32'd0);
    end

    // Output register; result/zero load every cycle, valid tracks in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'd0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= in_valid;
        end
    end

    assign aluctrl   = ctl;
    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  func;
    logic [1:0]  aluop;
    logic [2:0]  aluctrl;
    logic [31:0] result;
    logic        zero;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    alu_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .func      (func),
        .aluop     (aluop),
        .aluctrl   (aluctrl),
        .result    (result),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] m_ctl(input logic [1:0] op,
                                         input logic [5:0] fn);
        if (op == 2'd0) return 3'b010;
        if (op == 2'd1) return 3'b110;
        if (op == 2'd3) return 3'b011;
        case (fn)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [31:0] m_res(input logic [1:0] op,
                                          input logic [5:0] fn,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 2'd0) return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
        if (op == 2'd1) return 32'((64'(x) + 64'h1_0000_0000 - 64'(y)) % 64'h1_0000_0000);
        if (op == 2'd3) return 32'd0;
        case (fn)
            6'd32:   return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
            6'd34:   return 32'((64'(x) + 64'h1_0000_0000 - 64'(y)) % 64'h1_0000_0000);
            6'd36:   return x & y;
            6'd37:   return x | y;
            6'd42:   return (sx < sy) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [5:0] fn,
                         input logic [31:0] x, input logic [31:0] y);
        in_valid = v;
        aluop    = op;
        func     = fn;
        a        = x;
        b        = y;
    endtask

    // Apply one op, check aluctrl immediately and result/zero after the edge
    task automatic test_table(input string tag, input logic [1:0] op,
                              input logic [5:0] fn,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic [2:0] ectl,
                              input logic [31:0] eres);
        drive(1'b1, op, fn, x, y);
        #1;
        checks++;
        if (aluctrl !== ectl) begin
            errors++;
            $display("FAIL %s aluctrl got %b want %b", tag, aluctrl, ectl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result !== eres) begin
            errors++;
            $display("FAIL %s result got %h want %h", tag, result, eres);
        end
        checks++;
        if (zero !== (eres == 32'd0)) begin
            errors++;
            $display("FAIL %s zero got %b want %b", tag, zero, eres == 32'd0);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid got %b want 1", tag, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 2'b10, 6'b100000, 32'h45, 32'h85);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got r=%h z=%b v=%b want r=0 z=1 v=0",
                     result, zero, out_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        test_table("add", 2'b10, 6'b100000, 32'h45, 32'h85, 3'b010, 32'h0000_00CA);
        test_table("sub", 2'b10, 6'b100010, 32'h45, 32'h85, 3'b110, 32'hFFFF_FFC0);
    endtask

    task automatic test_logic();
        test_table("and", 2'b10, 6'b100100, 32'h45, 32'h85, 3'b000, 32'h0000_0005);
        test_table("or",  2'b10, 6'b100101, 32'h45, 32'h85, 3'b001, 32'h0000_00C5);
    endtask

    task automatic test_slt();
        test_table("slt_lt", 2'b10, 6'b101010, 32'h45, 32'h85, 3'b111, 32'd1);
        test_table("slt_ge", 2'b10, 6'b101010, 32'h85, 32'h45, 3'b111, 32'd0);
        test_table("slt_neg", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1);
        test_table("slt_eq", 2'b10, 6'b101010, 32'h8000_0000, 32'h8000_0000, 3'b111, 32'd0);
    endtask

    task automatic test_fixed();
        test_table("inv_func", 2'b10, 6'b111111, 32'h45, 32'h85, 3'b011, 32'd0);
        test_table("op00", 2'b00, 6'b100100, 32'h45, 32'h85, 3'b010, 32'h0000_00CA);
        test_table("op01", 2'b01, 6'b100100, 32'h45, 32'h85, 3'b110, 32'hFFFF_FFC0);
        test_table("op11", 2'b11, 6'b100000, 32'h45, 32'h85, 3'b011, 32'd0);
    endtask

    task automatic test_wrap();
        test_table("wrap_add", 2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0);
        test_table("wrap_sub", 2'b10, 6'b100010, 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF);
    endtask

    // Mid-stream reset with valid input: input dropped, state cleared
    task automatic test_reset_mid();
        drive(1'b1, 2'b10, 6'b100101, 32'h45, 32'h85);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 2'b10, 6'b100000, 32'h45, 32'h85);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got r=%h z=%b v=%b want r=0 z=1 v=0",
                     result, zero, out_valid);
        end
        rst = 1'b0;
        drive(1'b0, 2'b10, 6'b100000, 32'h45, 32'h85);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0000_00CA) begin
            errors++;
            $display("FAIL valid_lag0 got v=%b r=%h want v=0 r=000000ca",
                     out_valid, result);
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_lag1 got %b want 1", out_valid);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_lag2 got %b want 0", out_valid);
        end
    endtask

    // Back-to-back random traffic, a new op every cycle
    task automatic test_back_to_back();
        logic [5:0]  fns [6];
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] x;
        logic [31:0] y;
        logic        v;
        logic [31:0] eres;
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = fns[$urandom_range(0, 5)];
            if (fn == 6'd0) fn = 6'($urandom);
            x  = $urandom;
            y  = ($urandom_range(0, 7) == 0) ? x : 32'($urandom);
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            v  = 1'($urandom);
            drive(v, op, fn, x, y);
            eres = m_res(op, fn, x, y);
            #1;
            checks++;
            if (aluctrl !== m_ctl(op, fn)) begin
                errors++;
                $display("FAIL rnd_ctl op=%b fn=%b got %b want %b",
                         op, fn, aluctrl, m_ctl(op, fn));
            end
            @(posedge clk);
            #1;
            checks++;
            if (result !== eres || zero !== (eres == 32'd0) || out_valid !== v) begin
                errors++;
                $display("FAIL rnd_out op=%b fn=%b a=%h b=%h got r=%h z=%b v=%b want r=%h z=%b v=%b",
                         op, fn, x, y, result, zero, out_valid,
                         eres, eres == 32'd0, v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        test_reset();
        test_arith();
        test_logic();
        test_slt();
        test_fixed();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
